// File: rtl/sent_rx_crc_scheduler_if.sv
// Request/result bundle between the SENT RX frame decoders and the shared CRC scheduler.
// master: decoder/output-register side; slave: the scheduler.
interface sent_rx_crc_scheduler_if #(
  parameter int ERR_W = 16
);
  logic             en;
  logic             err_clr;
  logic             fast_valid;
  logic             fast_ready;
  logic [1:0]       fast_len;
  logic [27:0]      fast_data;
  logic             short_valid;
  logic             short_ready;
  logic [15:0]      short_data;
  logic             enh_valid;
  logic             enh_ready;
  logic [29:0]      enh_data;
  logic             out_valid;
  logic [1:0]       out_src;
  logic             out_crc_ok;
  logic [23:0]      out_data;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, err_clr,
    output fast_valid, fast_len, fast_data,
    output short_valid, short_data,
    output enh_valid, enh_data,
    input  fast_ready, short_ready, enh_ready,
    input  out_valid, out_src, out_crc_ok, out_data, err_cnt
  );

  modport slave (
    input  en, err_clr,
    input  fast_valid, fast_len, fast_data,
    input  short_valid, short_data,
    input  enh_valid, enh_data,
    output fast_ready, short_ready, enh_ready,
    output out_valid, out_src, out_crc_ok, out_data, err_cnt
  );
endinterface

// File: rtl/sent_rx_crc_scheduler.sv
// One bit-serial CRC4/CRC6 checker shared by the fast, short-serial and enhanced-serial
// SENT decoders; one buffered request per source, fixed priority fast > enhanced > short.
module sent_rx_crc_scheduler #(
  parameter logic [3:0] SEED4 = 4'h5,
  parameter logic [3:0] POLY4 = 4'hD,
  parameter logic [5:0] SEED6 = 6'h15,
  parameter logic [5:0] POLY6 = 6'h19,
  parameter int         ERR_W = 16
) (
  input logic                    clk,
  input logic                    reset,
  sent_rx_crc_scheduler_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic               fast_pend_q, fast_pend_d;
  logic [1:0]         fast_len_q, fast_len_d;
  logic [27:0]        fast_buf_q, fast_buf_d;
  logic               short_pend_q, short_pend_d;
  logic [15:0]        short_buf_q, short_buf_d;
  logic               enh_pend_q, enh_pend_d;
  logic [29:0]        enh_buf_q, enh_buf_d;

  logic [29:0]        msg_q, msg_d;
  logic [5:0]         r_q, r_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               wide_q, wide_d;
  logic [1:0]         src_q, src_d;
  logic [23:0]        pay_q, pay_d;

  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_src_q, out_src_d;
  logic               out_ok_q, out_ok_d;
  logic [23:0]        out_data_q, out_data_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [3:0]         r4_next;
  logic [5:0]         r_next;
  logic               err_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fast_pend_q  <= 1'b0;
      fast_len_q   <= '0;
      fast_buf_q   <= '0;
      short_pend_q <= 1'b0;
      short_buf_q  <= '0;
      enh_pend_q   <= 1'b0;
      enh_buf_q    <= '0;
      msg_q        <= '0;
      r_q          <= '0;
      cnt_q        <= '0;
      wide_q       <= 1'b0;
      src_q        <= '0;
      pay_q        <= '0;
      out_valid_q  <= 1'b0;
      out_src_q    <= '0;
      out_ok_q     <= 1'b0;
      out_data_q   <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      fast_pend_q  <= fast_pend_d;
      fast_len_q   <= fast_len_d;
      fast_buf_q   <= fast_buf_d;
      short_pend_q <= short_pend_d;
      short_buf_q  <= short_buf_d;
      enh_pend_q   <= enh_pend_d;
      enh_buf_q    <= enh_buf_d;
      msg_q        <= msg_d;
      r_q          <= r_d;
      cnt_q        <= cnt_d;
      wide_q       <= wide_d;
      src_q        <= src_d;
      pay_q        <= pay_d;
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      out_ok_q     <= out_ok_d;
      out_data_q   <= out_data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fast_pend_d  = fast_pend_q;
    fast_len_d   = fast_len_q;
    fast_buf_d   = fast_buf_q;
    short_pend_d = short_pend_q;
    short_buf_d  = short_buf_q;
    enh_pend_d   = enh_pend_q;
    enh_buf_d    = enh_buf_q;
    msg_d        = msg_q;
    r_d          = r_q;
    cnt_d        = cnt_q;
    wide_d       = wide_q;
    src_d        = src_q;
    pay_d        = pay_q;
    out_valid_d  = 1'b0;
    out_src_d    = out_src_q;
    out_ok_d     = out_ok_q;
    out_data_d   = out_data_q;
    err_inc      = 1'b0;

    // CRC4 residue lives in r_q[3:0]; the upper two bits stay zero.
    r4_next = {r_q[2:0], msg_q[29]} ^ (r_q[3] ? POLY4 : 4'h0);
    r_next  = wide_q ? ({r_q[4:0], msg_q[29]} ^ (r_q[5] ? POLY6 : 6'h00))
                     : {2'b00, r4_next};

    if (bus.fast_valid && !fast_pend_q) begin
      fast_pend_d = 1'b1;
      fast_len_d  = bus.fast_len;
      fast_buf_d  = bus.fast_data;
    end
    if (bus.short_valid && !short_pend_q) begin
      short_pend_d = 1'b1;
      short_buf_d  = bus.short_data;
    end
    if (bus.enh_valid && !enh_pend_q) begin
      enh_pend_d = 1'b1;
      enh_buf_d  = bus.enh_data;
    end

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          if (fast_pend_q) begin
            fast_pend_d = 1'b0;
            src_d       = 2'd0;
            wide_d      = 1'b0;
            r_d         = {2'b00, SEED4};
            state_d     = SHIFT;
            case (fast_len_q)
              2'd0: begin
                msg_d = {fast_buf_q[15:0], 14'b0};
                cnt_d = 5'd16;
                pay_d = {12'b0, fast_buf_q[15:4]};
              end
              2'd1: begin
                msg_d = {fast_buf_q[19:0], 10'b0};
                cnt_d = 5'd20;
                pay_d = {8'b0, fast_buf_q[19:4]};
              end
              2'd2: begin
                msg_d = {fast_buf_q[27:0], 2'b0};
                cnt_d = 5'd28;
                pay_d = fast_buf_q[27:4];
              end
              default: begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                out_src_d   = 2'd0;
                out_ok_d    = 1'b0;
                out_data_d  = '0;
                err_inc     = 1'b1;
              end
            endcase
          end else if (enh_pend_q) begin
            enh_pend_d = 1'b0;
            src_d      = 2'd2;
            wide_d     = 1'b1;
            r_d        = SEED6;
            msg_d      = enh_buf_q;
            cnt_d      = 5'd30;
            pay_d      = enh_buf_q[29:6];
            state_d    = SHIFT;
          end else if (short_pend_q) begin
            short_pend_d = 1'b0;
            src_d        = 2'd1;
            wide_d       = 1'b0;
            r_d          = {2'b00, SEED4};
            msg_d        = {short_buf_q, 14'b0};
            cnt_d        = 5'd16;
            pay_d        = {12'b0, short_buf_q[15:4]};
            state_d      = SHIFT;
          end
        end
      end
      SHIFT: begin
        msg_d = {msg_q[28:0], 1'b0};
        r_d   = r_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          out_valid_d = 1'b1;
          out_src_d   = src_q;
          out_ok_d    = (r_next == 6'h00);
          out_data_d  = pay_q;
          err_inc     = (r_next != 6'h00);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q;
    if (bus.err_clr) begin
      err_d = '0;
    end else if (err_inc && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  assign bus.fast_ready  = ~fast_pend_q;
  assign bus.short_ready = ~short_pend_q;
  assign bus.enh_ready   = ~enh_pend_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_src     = out_src_q;
  assign bus.out_crc_ok  = out_ok_q;
  assign bus.out_data    = out_data_q;
  assign bus.err_cnt     = err_q;

endmodule

// File: doc/sent_rx_crc_scheduler.md
Name: sent_rx_crc_scheduler

Overview:
- Shares one bit-serial CRC engine between the three SENT RX decoders: fast channel (3/4/6 data nibbles + CRC4), short serial (12 bits + CRC4) and enhanced serial (24 bits + CRC6).
- Buffers one request per source and arbitrates between them with fixed priority.
- Checks each frame by polynomial division and returns a pass/fail result with the payload stripped of its CRC.
- Sits between the RX frame decoders and the data/status output registers.

Parameters:
SEED4, 4'h5, CRC4 seed
POLY4, 4'hD, low 4 bits of x^4+x^3+x^2+1
SEED6, 6'h15, CRC6 seed
POLY6, 6'h19, low 6 bits of x^6+x^4+x^3+1
ERR_W, 16, error counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  grant enable; in-flight check always completes
err_clr  in  1  clears err_cnt
fast_valid  in  1  fast frame offered
fast_ready  out  1  = ~fast_pend
fast_len  in  2  0:3 nibbles, 1:4 nibbles, 2:6 nibbles, 3:illegal
fast_data  in  28  {data nibbles, CRC nibble}, right-aligned, MSB first
short_valid  in  1  short serial message offered
short_ready  out  1  = ~short_pend
short_data  in  16  {12-bit payload, CRC4}
enh_valid  in  1  enhanced serial message offered
enh_ready  out  1  = ~enh_pend
enh_data  in  30  {24-bit payload, CRC6}
out_valid  out  1  one-cycle result pulse
out_src  out  2  0 fast, 1 short, 2 enhanced
out_crc_ok  out  1  remainder == 0
out_data  out  24  payload, right-aligned, zero-extended
err_cnt  out  ERR_W  saturating count of failed checks

Behaviour:
- Reset: pending flags 0, FSM IDLE, out_valid/out_src/out_crc_ok/out_data 0, err_cnt 0, all *_ready 1. Reset mid-check abandons the check; no out_valid is produced.
- Accept: when x_valid & x_ready, data is captured into x_buf and x_pend is set at that edge. When x_ready = 0, x_valid is ignored. The pending flag clears on the grant edge, so ready is 1 from the cycle after the grant.
- Message length N: fast3 16, fast4 20, fast6 28, short 16, enhanced 30 bits.
- FSM IDLE:
  - If en and any pending flag: grant in priority order fast > enhanced > short.
  - On grant: load residue r = seed (SEED4, or SEED6 for enhanced); load the shift register with the message left-aligned in 30 bits; set cnt = N; clear that pending flag; go to SHIFT.
  - fast_len = 3: no shift; emit out_crc_ok = 0, out_src = 0, out_data = 0 at the grant edge, increment err_cnt; stay IDLE.
- FSM SHIFT:
  - Each cycle, b = msg MSB; fb = r[k-1]; r = {r[k-2:0], b} ^ (fb ? POLY : 0); msg <<= 1; cnt--.
  - On the edge with cnt == 1: register out_valid = 1, out_crc_ok = (next r == 0), out_src, out_data = message >> k; go to IDLE.
- Latency: accept in cycle c with engine idle -> grant in c+1 -> out_valid in cycle c+N+2. fast3 = 18, fast6 = 30, enhanced = 32.
- Back-to-back: the IDLE cycle coinciding with out_valid may grant the next pending request. Result-to-result spacing is N+1.
- out_valid is high for exactly one cycle. Other out_* fields hold until the next result.
- err_cnt: increments on each out_valid with out_crc_ok = 0. It saturates at all-ones. err_clr takes priority over a same-cycle increment, and the result is 0.
- en = 0: pending requests are held and can still be accepted; no new grants are made.

Test Plan:
1. fast_len=0, fast_data=16'h0009 accepted cycle c -> out_valid at c+18, out_src=0, out_crc_ok=1, out_data=0.
2. fast_len=0, fast_data=16'h0008 -> out_crc_ok=0, err_cnt=1; then err_clr -> err_cnt=0.
3. fast_len=2, fast_data=28'h0000005 -> ok=1 at c+30. enh_data={24'h0, 6'h26} -> out_src=2, ok=1 at c+32. enh CRC 6'h27 -> ok=0.
4. fast (len0, 0x0009) and short (0x0009) both accepted in cycle c -> fast result at c+18, short result at c+35. short_ready stays 0 until the cycle after the short grant.
5. Reset asserted 5 cycles into SHIFT for fast6 -> no out_valid; all ready = 1 and err_cnt = 0 the cycle after reset.
6. ERR_W=4 with 17 failing fast frames -> err_cnt holds 4'hF. fast_len=3 -> out_crc_ok=0 at c+2.
